melodia_microondas: RTL
=======================

# melodia_microondas

Tone generator that consumes the step index produced by the microwave step counter. It turns each step value into an audible square wave on a buzzer pin, and inserts a short silent gap whenever the step changes so that repeated notes stay distinct. It also flags the last step of the melody. It runs on the fast board clock and samples the counter's slow-domain output safely.

## Interface
Parameters:
- CLK_HZ, 50_000_000, board clock frequency; sets the note half-period table.
- GAP_CYCLES, 2_500_000, length of the silence inserted on every step change (50 ms).
- LAST_STEP, 21, step value that raises `done`.

Ports:
- clk  in  1  board clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- activado  in  1  player enable; low forces silence and returns to IDLE.
- step  in  8  step index from the step counter; slow domain, changes asynchronously to clk.
- buzzer  out  1  square-wave tone output.
- sonando  out  1  high while a non-rest note is being generated (state PLAY with half-period ≠ 0).
- done  out  1  single-cycle pulse on acceptance of step == LAST_STEP.

## Operation
Input capture:
- `step` passes through a two-flop synchronizer: s1, then s2.
- A value is accepted only when s1 == s2 (stable for 2 consecutive samples).
- The value must also differ from `cur_step`. On acceptance, `cur_step` <= s2.

Note lookup:
- Combinational ROM maps `cur_step` to an 18-bit half-period.
- Step 0 and any step > 21 map to 0 (rest).
- Steps 1..21 are the C-major scale C4..B6, equal temperament with A4 = 440 Hz; half = round(CLK_HZ / (2·f)).
- Required table entries: step 1 = 95556, step 6 = 56818, step 8 = 47778.

State machine, states IDLE, GAP, PLAY:
- IDLE:
  - buzzer = 0; `cur_step` held at 0.
  - When activado = 1 and a step ≠ 0 is accepted: go to GAP.
- GAP:
  - buzzer = 0; gap counter counts 0..GAP_CYCLES-1.
  - On terminal count: go to PLAY, with divider = 0.
  - A new accepted step restarts the gap counter at 0.
- PLAY:
  - Divider counts 0..half-1. On half-1, buzzer toggles and the divider clears.
  - If half = 0 (rest), buzzer is held at 0 and the divider is held at 0.
  - A new accepted step: go to GAP; buzzer = 0 and the divider clears in the same cycle.
- Any state, activado = 0: next state is IDLE, with buzzer, counters and `cur_step` cleared.
- `done`:
  - Asserted for one cycle in the cycle after acceptance of LAST_STEP while activado = 1.
  - Not re-asserted until a different step has been accepted.

## Timing
- Reset value of every output and internal register is 0; reset state is IDLE.
- Reset mid-note takes effect immediately (asynchronous). Release is sampled on the first clk edge with rst_n high.
- Latency from a `step` change to acceptance is 3 clk edges (s1, s2, compare/update). GAP is entered on the same edge as acceptance.
- GAP lasts exactly GAP_CYCLES cycles. The first buzzer rising edge comes half cycles after entering PLAY.
- Tone period is 2·half cycles, duty 50 %.
- Simultaneous deassertion of activado and step acceptance: activado wins (IDLE, no `done`).
- Step glitches shorter than 2 clk samples are never accepted.

## Structure
- Package `musica_pkg`:
  - NOTE_HALF constant array [0:21] of 18-bit values.
  - State enum {IDLE, GAP, PLAY}.
  - MAX_STEP = 21.
- Sub-module `divisor_tono`: the loadable half-period divider with clear and hold-at-zero. It is instantiated once in PLAY.
- The rest of the block (top level) holds the synchronizer, FSM and done logic.

## Test plan
Simulation uses CLK_HZ = 50_000_000 and GAP_CYCLES = 100.
- Reset, then activado = 1 and step = 1 → GAP for 100 cycles, then buzzer toggles every 95556 cycles; sonando = 1.
- Step 1 → 6 during PLAY → buzzer forced to 0 within 3 cycles of the change, 100-cycle gap, then period 113636 cycles.
- Step stepped 20 → 21 → done high for exactly 1 cycle, 3 cycles after the change; holding 21 gives no second pulse.
- Step pulsed to 8 for 1 cycle then back → no acceptance, no GAP, tone continues unchanged.
- activado dropped during GAP and during PLAY → IDLE next cycle, buzzer = 0, sonando = 0, done = 0.
- rst_n pulsed low mid-PLAY (asynchronous to clk) → all outputs 0 immediately; step 0 then gives rest (sonando = 0, buzzer = 0).

Source files
------------

// File: rtl/musica_pkg.sv
// Shared definitions for the microwave melody player.
//   MAX_STEP   : highest step index that carries a note (C4..B6, 21 notes)
//   estado_t   : player states IDLE / GAP / PLAY
//   NOTE_UHZ   : note frequencies in micro-hertz, indexed by step (0 = rest)
//   note_half  : half-period in clock cycles for a note at a given clock
//   NOTE_HALF  : half-period table for the 50 MHz board clock
package musica_pkg;

  localparam int MAX_STEP = 21;
  localparam int HALF_W   = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } estado_t;

  // Equal temperament, A4 = 440 Hz, C-major scale from C4 to B6.
  // Micro-hertz resolution keeps the rounded half-periods exact even at 50 MHz.
  localparam longint NOTE_UHZ [0:MAX_STEP] = '{
    0,
    261625565, 293664768, 329627557, 349228231, 391995436, 440000000, 493883301,
    523251131, 587329536, 659255114, 698456463, 783990872, 880000000, 987766603,
    1046502261, 1174659072, 1318510228, 1396912926, 1567981744, 1760000000, 1975533205
  };

  // round(clk_hz / (2 f)); intended for elaboration-time use only.
  function automatic logic [HALF_W-1:0] note_half(input longint clk_hz, input int idx);
    logic [HALF_W-1:0] h;
    longint f;
    h = '0;
    f = 0;
    if (idx >= 1 && idx <= MAX_STEP) begin
      f = NOTE_UHZ[5'(idx)];
      h = HALF_W'((clk_hz * 64'sd1000000 + f) / (64'sd2 * f));
    end
    return h;
  endfunction

  localparam logic [HALF_W-1:0] NOTE_HALF [0:MAX_STEP] = '{
    note_half(50_000_000, 0),
    note_half(50_000_000, 1),  note_half(50_000_000, 2),  note_half(50_000_000, 3),
    note_half(50_000_000, 4),  note_half(50_000_000, 5),  note_half(50_000_000, 6),
    note_half(50_000_000, 7),  note_half(50_000_000, 8),  note_half(50_000_000, 9),
    note_half(50_000_000, 10), note_half(50_000_000, 11), note_half(50_000_000, 12),
    note_half(50_000_000, 13), note_half(50_000_000, 14), note_half(50_000_000, 15),
    note_half(50_000_000, 16), note_half(50_000_000, 17), note_half(50_000_000, 18),
    note_half(50_000_000, 19), note_half(50_000_000, 20), note_half(50_000_000, 21)
  };

endpackage

// File: rtl/divisor_tono.sv
// Loadable half-period divider producing a 50 % duty square wave.
//   clk, rst_n : board clock, asynchronous active-low reset
//   run        : high while the player is in PLAY; low clears counter and tone
//   half       : half-period in clock cycles; 0 means rest (tone held low)
//   tone       : registered square-wave output
module divisor_tono
  import musica_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [HALF_W-1:0] half,
  output logic              tone
);

  logic [HALF_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!run || half == '0) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half - HALF_W'(1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/melodia_microondas.sv
// Melody player: turns the step counter's index into a buzzer tone, with a
// silent gap on every step change and a pulse on the last step.
//   clk, rst_n : board clock, asynchronous active-low reset
//   activado   : player enable; low silences and returns to IDLE
//   step       : step index from the slow-domain counter (asynchronous)
//   buzzer     : square-wave tone
//   sonando    : high while a non-rest note is playing
//   done       : one-cycle pulse when LAST_STEP is accepted
module melodia_microondas
  import musica_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int GAP_CYCLES = 2_500_000,
  parameter int LAST_STEP  = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activado,
  input  logic [7:0] step,
  output logic       buzzer,
  output logic       sonando,
  output logic       done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [7:0]        s1, s2, cur_step;
  estado_t           state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HALF_W-1:0] half;
  logic              accept, run;

  // Note ROM: 32 entries so any 5-bit index is in range; steps above 21 rest.
  logic [HALF_W-1:0] half_rom [0:31];
  for (genvar i = 0; i < 32; i++) begin : g_rom
    if (i <= MAX_STEP) begin : g_note
      localparam logic [HALF_W-1:0] H =
        (CLK_HZ == 50_000_000) ? NOTE_HALF[i] : note_half(CLK_HZ, i);
      assign half_rom[i] = H;
    end else begin : g_rest
      assign half_rom[i] = '0;
    end
  end

  assign half = (cur_step[7:5] == 3'd0) ? half_rom[cur_step[4:0]] : '0;

  // A value is trusted only once both synchronizer flops agree on it.
  assign accept = (s1 == s2) && (s2 != cur_step);

  // The divider is cleared on the very edge that accepts a new step.
  assign run = activado && (state == PLAY) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      cur_step <= '0;
      state    <= IDLE;
      gap_cnt  <= '0;
      sonando  <= 1'b0;
      done     <= 1'b0;
    end else begin
      s1   <= step;
      s2   <= s1;
      done <= 1'b0;
      if (!activado) begin
        state    <= IDLE;
        cur_step <= '0;
        gap_cnt  <= '0;
        sonando  <= 1'b0;
      end else if (accept) begin
        // In IDLE cur_step is 0, so any accepted value here is a real step.
        cur_step <= s2;
        state    <= GAP;
        gap_cnt  <= '0;
        sonando  <= 1'b0;
        done     <= (s2 == 8'(LAST_STEP));
      end else begin
        unique case (state)
          IDLE: ;
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state   <= PLAY;
              gap_cnt <= '0;
              sonando <= (half != '0);
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          PLAY: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  divisor_tono u_divisor (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .half  (half),
    .tone  (buzzer)
  );

endmodule
